// File: rtl/soc_map_pkg.sv
// ----------------------------------------------------------------------------
// soc_map : shared SoC address map for the data-RAM responder.
//   MMIO_BASE         first byte address of the 4-word MMIO window
//   *_OFS             byte offsets of the MMIO registers inside the window
//   target_e          decoded target of a data-RAM access
//   decodeTarget()    word index -> target, purely combinational
// ----------------------------------------------------------------------------
package soc_map;

   localparam int unsigned MMIO_BASE = 32'h0000_00F0;

   localparam int unsigned LED_OFS = 0;
   localparam int unsigned SW_OFS  = 4;
   localparam int unsigned CYC_OFS = 8;
   localparam int unsigned WRC_OFS = 12;

   typedef enum logic [2:0] {
      ARRAY = 3'd0,
      LED   = 3'd1,
      SW    = 3'd2,
      CYC   = 3'd3,
      WRC   = 3'd4,
      NONE  = 3'd5
   } target_e;

   // Everything below the MMIO window is data array; unmapped words decode to NONE.
   function automatic target_e decodeTarget(input int unsigned wordIdx,
                                            input int unsigned base);
      target_e t;
      t = NONE;
      if (wordIdx < (base >> 2))                     t = ARRAY;
      else if (wordIdx == ((base + LED_OFS) >> 2))   t = LED;
      else if (wordIdx == ((base + SW_OFS)  >> 2))   t = SW;
      else if (wordIdx == ((base + CYC_OFS) >> 2))   t = CYC;
      else if (wordIdx == ((base + WRC_OFS) >> 2))   t = WRC;
      return t;
   endfunction

endpackage

// File: rtl/sync2.sv
// ----------------------------------------------------------------------------
// sync2 : parameterised-width two-flop synchroniser, async active-high reset.
//   iCLK  destination clock
//   iRST  asynchronous active-high reset, clears both stages
//   iD    asynchronous input bus
//   oQ    synchronised output, follows iD two rising edges later
// ----------------------------------------------------------------------------
module sync2 #(
   parameter int unsigned W = 8
) (
   input  logic         iCLK,
   input  logic         iRST,
   input  logic [W-1:0] iD,
   output logic [W-1:0] oQ
);

   logic [W-1:0] meta;

   // First stage may go metastable; second stage gives it a cycle to settle.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         meta <= '0;
         oQ   <= '0;
      end else begin
         meta <= iD;
         oQ   <= meta;
      end
   end

endmodule

// File: rtl/data_ram_responder.sv
// ----------------------------------------------------------------------------
// data_ram_responder : target side of the core's data-RAM port.
// Word-organised data array below MMIO_BASE plus a 4-word MMIO window
// (LED, synchronised switches, cycle counter, array write counter).
//   iCLK, iRST      clock and asynchronous active-high reset
//   iRAM_CE/RD/WR   chip enable, read and write strobes from the core
//   iRAM_ADDR       byte address, ADDR[1:0] ignored
//   iRAM_DATA       write data
//   oRAM_DATA       combinational read data, 0 unless CE & RD
//   iSW             asynchronous board switches
//   oLED            low bits of the LED register
//   oWR_CNT         saturating count of accepted array writes
// ----------------------------------------------------------------------------
module data_ram_responder #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MMIO_BASE = soc_map::MMIO_BASE,
   parameter int unsigned SW_W      = 8,
   parameter int unsigned LED_W     = 8
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iRAM_CE,
   input  logic              iRAM_RD,
   input  logic              iRAM_WR,
   input  logic [ADDR_W-1:0] iRAM_ADDR,
   input  logic [DATA_W-1:0] iRAM_DATA,
   output logic [DATA_W-1:0] oRAM_DATA,
   input  logic [SW_W-1:0]   iSW,
   output logic [LED_W-1:0]  oLED,
   output logic [DATA_W-1:0] oWR_CNT
);

   import soc_map::*;

   localparam int unsigned WIDX_W    = ADDR_W - 2;
   localparam int unsigned NUM_WORDS = MMIO_BASE >> 2;
   localparam int unsigned AIDX_W    = $clog2(NUM_WORDS);

   logic [WIDX_W-1:0] wordIdx;
   logic [AIDX_W-1:0] arrIdx;
   target_e           tgt;
   logic              rdEn;
   logic              wrEn;
   logic              arrWr;
   logic              ledWr;
   logic              cycWr;
   logic              unusedAddrLsb;

   logic [DATA_W-1:0] dataArr [NUM_WORDS];
   logic [DATA_W-1:0] ledReg;
   logic [DATA_W-1:0] cycCnt;
   logic [DATA_W-1:0] wrCnt;
   logic [SW_W-1:0]   swSync;

   // Byte lanes are not supported; the low address bits are dropped.
   assign unusedAddrLsb = &{1'b0, iRAM_ADDR[1:0]};

   // Address decode, purely combinational.
   assign wordIdx = iRAM_ADDR[ADDR_W-1:2];
   assign arrIdx  = AIDX_W'(wordIdx);
   assign tgt     = decodeTarget(32'(wordIdx), MMIO_BASE);

   // CE gates every strobe, so an undriven address while CE=0 cannot write.
   assign rdEn  = iRAM_CE & iRAM_RD;
   assign wrEn  = iRAM_CE & iRAM_WR;
   assign arrWr = wrEn && (tgt == ARRAY);
   assign ledWr = wrEn && (tgt == LED);
   assign cycWr = wrEn && (tgt == CYC);

   // Data array: single write port, no reset, so it maps onto a RAM macro.
   always_ff @(posedge iCLK) begin
      if (arrWr) begin
         dataArr[arrIdx] <= iRAM_DATA;
      end
   end

   // MMIO registers and free-running counters.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         ledReg <= '0;
         cycCnt <= '0;
         wrCnt  <= '0;
      end else begin
         if (ledWr) begin
            ledReg <= iRAM_DATA;
         end
         // The written value counts as this cycle's count, so the following
         // cycle already reads it plus one.
         if (cycWr) begin
            cycCnt <= iRAM_DATA + DATA_W'(1);
         end else begin
            cycCnt <= cycCnt + DATA_W'(1);
         end
         if (arrWr && (wrCnt != '1)) begin
            wrCnt <= wrCnt + DATA_W'(1);
         end
      end
   end

   sync2 #(
      .W (SW_W)
   ) swSyncInst (
      .iCLK (iCLK),
      .iRST (iRST),
      .iD   (iSW),
      .oQ   (swSync)
   );

   // Zero-wait-state read mux; sees pre-write state when RD and WR coincide.
   always_comb begin
      oRAM_DATA = '0;
      if (rdEn) begin
         case (tgt)
            ARRAY:   oRAM_DATA = dataArr[arrIdx];
            LED:     oRAM_DATA = ledReg;
            SW:      oRAM_DATA = DATA_W'(swSync);
            CYC:     oRAM_DATA = cycCnt;
            WRC:     oRAM_DATA = wrCnt;
            default: oRAM_DATA = '0;
         endcase
      end
   end

   assign oLED    = ledReg[LED_W-1:0];
   assign oWR_CNT = wrCnt;

endmodule

// File: tb/tb_data_ram_responder.sv
// ----------------------------------------------------------------------------
// tb_data_ram_responder : directed and random bench for data_ram_responder.
// A word-level reference model (arrays and counters updated once per clock)
// supplies the expected read data, LED and write-count values.
// ----------------------------------------------------------------------------
module tb_data_ram_responder;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iRAM_CE;
   logic        iRAM_RD;
   logic        iRAM_WR;
   logic [7:0]  iRAM_ADDR;
   logic [31:0] iRAM_DATA;
   logic [31:0] oRAM_DATA;
   logic [7:0]  iSW;
   logic [7:0]  oLED;
   logic [31:0] oWR_CNT;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [31:0] mMem [60];
   bit          mValid [60];
   logic [31:0] mLed;
   logic [31:0] mCyc;
   logic [31:0] mWrc;
   logic [7:0]  mSw1;
   logic [7:0]  mSw2;

   data_ram_responder dut (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iRAM_CE   (iRAM_CE),
      .iRAM_RD   (iRAM_RD),
      .iRAM_WR   (iRAM_WR),
      .iRAM_ADDR (iRAM_ADDR),
      .iRAM_DATA (iRAM_DATA),
      .oRAM_DATA (oRAM_DATA),
      .iSW       (iSW),
      .oLED      (oLED),
      .oWR_CNT   (oWR_CNT)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic mReset();
      mLed = '0;
      mCyc = '0;
      mWrc = '0;
      mSw1 = '0;
      mSw2 = '0;
   endtask

   function automatic bit mKnown(input logic [7:0] a);
      int unsigned idx;
      idx = int'(a) >> 2;
      return (idx < 60) ? mValid[idx] : 1'b1;
   endfunction

   function automatic logic [31:0] mRead(input logic [7:0] a);
      int unsigned idx;
      idx = int'(a) >> 2;
      if (idx < 60)  return mMem[idx];
      if (idx == 60) return mLed;
      if (idx == 61) return {24'h0, mSw2};
      if (idx == 62) return mCyc;
      return mWrc;
   endfunction

   // One bus cycle, starting and ending at a falling edge.
   task automatic step(input bit ce, input bit rd, input bit wr,
                       input logic [7:0] addr, input logic [31:0] data,
                       output logic [31:0] rdv);
      int unsigned idx;
      bit          cycLoad;
      logic [7:0]  swEdge;
      iRAM_CE   = ce;
      iRAM_RD   = rd;
      iRAM_WR   = wr;
      iRAM_ADDR = addr;
      iRAM_DATA = data;
      #1;
      rdv = oRAM_DATA;
      if (ce && rd) begin
         if (mKnown(addr)) chk($sformatf("rd@%h", addr), rdv, mRead(addr));
      end else begin
         chk($sformatf("idle@%h", addr), rdv, 32'h0);
      end
      swEdge = iSW;
      @(posedge iCLK);
      idx     = int'(addr) >> 2;
      cycLoad = 1'b0;
      if (ce && wr) begin
         if (idx < 60) begin
            mMem[idx]   = data;
            mValid[idx] = 1'b1;
            if (mWrc != 32'hFFFF_FFFF) mWrc = mWrc + 1;
         end else if (idx == 60) begin
            mLed = data;
         end else if (idx == 62) begin
            cycLoad = 1'b1;
         end
      end
      mCyc = cycLoad ? data + 32'd1 : mCyc + 32'd1;
      mSw2 = mSw1;
      mSw1 = swEdge;
      #1;
      chk("led", {24'h0, oLED}, {24'h0, mLed[7:0]});
      chk("wrcnt", oWR_CNT, mWrc);
      @(negedge iCLK);
   endtask

   initial begin
      logic [31:0] r;
      bit          ce, rd, wr;
      logic [7:0]  a;

      for (int i = 0; i < 60; i++) mValid[i] = 1'b0;
      iRST = 1'b1; iRAM_CE = 1'b0; iRAM_RD = 1'b0; iRAM_WR = 1'b0;
      iRAM_ADDR = '0; iRAM_DATA = '0; iSW = '0;
      mReset();
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      chk("rst_led", {24'h0, oLED}, 32'h0);
      chk("rst_wrcnt", oWR_CNT, 32'h0);
      iRST = 1'b0;

      // Reset state of the MMIO window.
      step(1, 1, 0, 8'hF0, 32'h0, r); chk("led_rd", r, 32'h0);
      step(1, 1, 0, 8'hF8, 32'h0, r); chk("cyc_small", {31'h0, (r < 32'd16)}, 32'h1);
      step(1, 1, 0, 8'hFC, 32'h0, r); chk("wrc_rd", r, 32'h0);

      // Basic write then read.
      step(1, 0, 1, 8'h10, 32'hDEADBEEF, r);
      step(1, 1, 0, 8'h10, 32'h0, r); chk("arr_10", r, 32'hDEADBEEF);
      step(1, 1, 0, 8'hFC, 32'h0, r); chk("wrc_1", r, 32'h1);
      chk("oWR_CNT_1", oWR_CNT, 32'h1);

      // Simultaneous read and write returns the old word.
      step(1, 0, 1, 8'h20, 32'h11111111, r);
      step(1, 1, 1, 8'h20, 32'h22222222, r); chk("rdwr_old", r, 32'h11111111);
      step(1, 1, 0, 8'h20, 32'h0, r); chk("rdwr_new", r, 32'h22222222);

      // Switch synchroniser latency and read-only write.
      iSW = 8'hA5;
      step(1, 1, 0, 8'hF4, 32'h0, r); chk("sw_0edge", r, 32'h0);
      step(1, 1, 0, 8'hF4, 32'h0, r); chk("sw_1edge", r, 32'h0);
      step(1, 1, 0, 8'hF4, 32'h0, r); chk("sw_2edge", r, 32'h000000A5);
      step(1, 0, 1, 8'hF4, 32'h1234, r);
      step(1, 1, 0, 8'hF4, 32'h0, r); chk("sw_ro", r, 32'h000000A5);
      step(1, 1, 0, 8'hFC, 32'h0, r); chk("wrc_ro", r, 32'h3);

      // Cycle counter load and wrap, LED load.
      step(1, 0, 1, 8'hF8, 32'hFFFFFFFE, r);
      step(1, 1, 0, 8'hF8, 32'h0, r); chk("cyc_ld", r, 32'hFFFFFFFF);
      step(1, 1, 0, 8'hF8, 32'h0, r); chk("cyc_wrap", r, 32'h0);
      step(1, 0, 1, 8'hF0, 32'h3C, r);
      chk("oled_3c", {24'h0, oLED}, 32'h3C);

      // Asynchronous reset in the middle of a cycle.
      iRAM_CE = 1'b1; iRAM_RD = 1'b1; iRAM_WR = 1'b0; iRAM_ADDR = 8'hF8;
      #2 iRST = 1'b1;
      #1;
      chk("arst_led", {24'h0, oLED}, 32'h0);
      chk("arst_wrcnt", oWR_CNT, 32'h0);
      chk("arst_cyc", oRAM_DATA, 32'h0);
      mReset();
      mSw1 = 8'hA5;
      @(negedge iCLK);
      mSw1 = '0;
      iRST = 1'b0;

      // CE low blocks writes; array survives reset.
      step(0, 0, 1, 8'h10, 32'hCAFEF00D, r);
      step(1, 1, 0, 8'h13, 32'h0, r); chk("ce0_arr", r, 32'hDEADBEEF);
      step(1, 1, 0, 8'hFC, 32'h0, r); chk("ce0_wrc", r, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         ce = ($urandom_range(0, 7) != 0);
         rd = 1'($urandom_range(0, 1));
         wr = ($urandom_range(0, 2) == 0);
         a  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) iSW = 8'($urandom);
         step(ce, rd, wr, a, $urandom, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
